// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the instruction/data memory arbiter
package mem_arb_pkg;

  // RAM-side handshake status reported by the memory each cycle
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Arbiter ownership of the RAM port
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } arb_state_t;

  typedef logic [31:0] word_t;

  // Data grants tolerated while a fetch waits before the fetch is forced through
  localparam logic [2:0] FAIR_LIMIT = 3'd4;

endpackage

// File: rtl/arb_fair_ctr.sv
// rtl/arb_fair_ctr.sv - counts data grants that bypassed a waiting instruction fetch
module arb_fair_ctr
  import mem_arb_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_limit_o
);

  logic [2:0] cnt_q;

  // Clear wins over increment; saturate so the count can never wrap back below the limit
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 3'd0;
    end else if (clr_i) begin
      cnt_q <= 3'd0;
    end else if (inc_i && (cnt_q != 3'd7)) begin
      cnt_q <= cnt_q + 3'd1;
    end
  end

  assign at_limit_o = (cnt_q >= FAIR_LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - instruction/data memory arbiter; ARB_FAIR_EN enables fetch fairness
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic      CLK,
  input  logic      RST,
  input  logic      halt,
  input  logic      iREN,
  input  word_t     iaddr,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  input  ramstate_t ramstate,
  input  word_t     ramload,
  output logic      iwait,
  output logic      dwait,
  output word_t     iload,
  output word_t     dload,
  output word_t     ramaddr,
  output word_t     ramstore,
  output logic      ramREN,
  output logic      ramWEN
);

  arb_state_t state_q;
  word_t      addr_q;
  word_t      store_q;
  logic       wr_q;

  logic data_req;
  logic instr_ok;
  logic d_active;
  logic i_active;
  logic d_done;
  logic i_done;
  logic go_d;
  logic go_i;
  logic fair_force;

`ifdef ARB_FAIR_EN
  logic fair_at_limit;
  logic fair_inc;
  logic fair_clr;

  // A forced fetch only makes sense when a fetch is actually allowed to issue
  always_comb begin
    fair_force = (state_q == IDLE) && fair_at_limit && instr_ok;
    fair_inc   = go_d && instr_ok;
    fair_clr   = go_i;
  end

  arb_fair_ctr u_fair_ctr (
    .clk_i      (CLK),
    .rst_i      (RST),
    .inc_i      (fair_inc),
    .clr_i      (fair_clr),
    .at_limit_o (fair_at_limit)
  );
`else
  assign fair_force = 1'b0;
`endif

  // Request qualification and completion detection for the current owner
  always_comb begin
    data_req = dREN | dWEN;
    instr_ok = iREN & ~halt;
    d_active = (state_q == DGRANT) && data_req;
    i_active = (state_q == IGRANT) && iREN;
    d_done   = d_active && (ramstate == ACCESS);
    i_done   = i_active && (ramstate == ACCESS);
    go_i     = (state_q == IDLE) && (fair_force || (!data_req && instr_ok));
    go_d     = (state_q == IDLE) && !fair_force && data_req;
  end

  // Ownership FSM; latches the winning request's address, data and direction on grant
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      store_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (go_i) begin
            state_q <= IGRANT;
            addr_q  <= iaddr;
            store_q <= '0;
            wr_q    <= 1'b0;
          end else if (go_d) begin
            state_q <= DGRANT;
            addr_q  <= daddr;
            store_q <= dWEN ? dstore : '0;
            wr_q    <= dWEN;
          end
        end
        DGRANT: begin
          if (!data_req || d_done) begin
            state_q <= IDLE;
          end
        end
        IGRANT: begin
          // halt is deliberately ignored here so an in-flight fetch is never cut short
          if (!iREN || i_done) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // RAM drive and requester responses; enables drop in the same cycle a requester aborts
  always_comb begin
    ramaddr  = (state_q != IDLE) ? addr_q  : '0;
    ramstore = (state_q != IDLE) ? store_q : '0;
    ramWEN   = d_active & wr_q;
    ramREN   = (d_active & ~wr_q) | i_active;
    iwait    = iREN & ~i_done;
    dwait    = data_req & ~d_done;
    iload    = i_done ? ramload : '0;
    dload    = (d_done && !wr_q) ? ramload : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized self-checking bench for mem_arbiter
module tb_mem_arbiter;
  import mem_arb_pkg::*;

`ifdef ARB_FAIR_EN
  localparam bit FAIR_EN = 1'b1;
`else
  localparam bit FAIR_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST, halt, iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  ramstate_t   ramstate;
  logic        iwait, dwait, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the RAM (0 none, 1 data, 2 instruction) and what was captured
  int          m_owner;
  logic [31:0] m_addr, m_store;
  logic        m_wr;
  int          m_fair;

  logic [4:0]  kinds;
  int          n_grants;

  mem_arbiter dut (
    .CLK(CLK), .RST(RST), .halt(halt), .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .ramstate(ramstate), .ramload(ramload),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramREN(ramREN), .ramWEN(ramWEN)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=still running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every output against what the ownership rules demand for the current inputs
  task automatic sample();
    logic dreq, act, acc, dgr;
    @(negedge CLK);
    dreq = dREN | dWEN;
    act  = (m_owner == 1) ? dreq : (m_owner == 2) ? iREN : 1'b0;
    acc  = act && (ramstate == ACCESS);
    dgr  = (m_owner == 1);
    chk("ramaddr",  ramaddr,  (m_owner != 0) ? m_addr  : 32'h0);
    chk("ramstore", ramstore, (m_owner != 0) ? m_store : 32'h0);
    chk("ramWEN",   ramWEN,   act && dgr && m_wr);
    chk("ramREN",   ramREN,   act && !(dgr && m_wr));
    chk("iwait",    iwait,    iREN && !(acc && m_owner == 2));
    chk("dwait",    dwait,    dreq && !(acc && dgr));
    chk("iload",    iload,    (acc && m_owner == 2) ? ramload : 32'h0);
    chk("dload",    dload,    (acc && dgr && !m_wr) ? ramload : 32'h0);
  endtask

  // Apply the clock edge to the model, then move off the edge for new stimulus
  task automatic advance();
    logic dreq, iok, acc;
    @(posedge CLK);
    dreq = dREN | dWEN;
    iok  = iREN && !halt;
    acc  = (ramstate == ACCESS);
    if (RST) begin
      m_owner = 0; m_addr = 0; m_store = 0; m_wr = 0; m_fair = 0;
    end else if (m_owner == 0) begin
      if (FAIR_EN && m_fair >= FAIR_LIMIT && iok) begin
        m_owner = 2; m_addr = iaddr; m_store = 0; m_wr = 0; m_fair = 0;
      end else if (dreq) begin
        m_owner = 1; m_addr = daddr; m_wr = dWEN; m_store = dWEN ? dstore : 32'h0;
        if (iok) m_fair++;
      end else if (iok) begin
        m_owner = 2; m_addr = iaddr; m_store = 0; m_wr = 0; m_fair = 0;
      end
    end else if (m_owner == 1) begin
      if (!dreq || acc) m_owner = 0;
    end else begin
      if (!iREN || acc) m_owner = 0;
    end
    #1;
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  task automatic quiet();
    halt = 0; iREN = 0; dREN = 0; dWEN = 0; ramstate = FREE; ramload = 0;
  endtask

  initial begin
    m_owner = 0; m_addr = 0; m_store = 0; m_wr = 0; m_fair = 0;
    quiet();
    iaddr = 0; daddr = 32'h10; dstore = 32'h55; RST = 1; dWEN = 1;

    // Reset held two cycles with a write pending
    advance();
    sample(); chk("rst_hold_wen", ramWEN, 1'b0);
    advance();
    RST = 0;
    sample(); chk("rst_fall_wen", ramWEN, 1'b0);
    advance();
    ramstate = ACCESS;
    sample(); chk("wen_after_rst", ramWEN, 1'b1);
    advance();
    quiet(); step(); step();

    // Single fetch: grant on cycle 2, RAM answers on cycle 3
    iREN = 1; iaddr = 32'h0000_0040;
    step();
    sample(); chk("fetch_c2_ren", ramREN, 1'b1); chk("fetch_c2_iwait", iwait, 1'b1);
    advance();
    ramstate = ACCESS; ramload = 32'hDEAD_BEEF;
    sample(); chk("fetch_c3_iload", iload, 32'hDEAD_BEEF); chk("fetch_c3_iwait", iwait, 1'b0);
    chk("fetch_c3_ren", ramREN, 1'b1);
    advance();
    quiet();
    sample(); chk("fetch_c4_iload", iload, 32'h0);
    advance();

    // Simultaneous requests: data first, then one IDLE cycle, then the fetch
    iREN = 1; iaddr = 32'h200; dREN = 1; daddr = 32'h100;
    step();
    sample(); chk("simul_first_addr", ramaddr, 32'h100);
    advance();
    ramstate = ACCESS; ramload = 32'h0BAD_F00D;
    sample(); chk("simul_dload", dload, 32'h0BAD_F00D); chk("simul_iwait", iwait, 1'b1);
    advance();
    dREN = 0; ramstate = FREE;
    sample(); chk("simul_idle_ren", ramREN, 1'b0);
    advance();
    sample(); chk("simul_second_addr", ramaddr, 32'h200);
    advance();
    ramstate = ACCESS; step();
    quiet(); step();

    // Read+write together is a write
    dREN = 1; dWEN = 1; daddr = 32'h8; dstore = 32'h1234;
    step();
    sample(); chk("wr_wen", ramWEN, 1'b1); chk("wr_ren", ramREN, 1'b0);
    chk("wr_store", ramstore, 32'h1234);
    advance();
    ramstate = ACCESS; step();
    quiet(); step();

    // Abort: data read drops while RAM is busy
    dREN = 1; daddr = 32'h44; ramstate = BUSY;
    step(); step();
    ramstate = ERROR; step();
    dREN = 0; ramstate = BUSY;
    sample(); chk("abort_ren", ramREN, 1'b0);
    advance();
    sample(); chk("abort_idle_addr", ramaddr, 32'h0);
    advance();

    // Fairness: fetch held while data writes keep coming, RAM always ready
    iREN = 1; iaddr = 32'h300; dWEN = 1; daddr = 32'h400; dstore = 32'h77; ramstate = ACCESS;
    kinds = 0; n_grants = 0;
    for (int c = 0; c < 12; c++) begin
      sample();
      if ((ramWEN || ramREN) && n_grants < 5) begin
        kinds[n_grants] = ramWEN;
        n_grants++;
      end
      advance();
    end
    chk("fair_grant_count", n_grants, 5);
    chk("fair_first_four", kinds[3:0], 4'hF);
    chk("fair_fifth", kinds[4], FAIR_EN ? 32'd0 : 32'd1);
    quiet(); step(); step();

    // Reset in the middle of a transfer
    dREN = 1; daddr = 32'h88; ramstate = BUSY;
    step(); step();
    RST = 1; step();
    RST = 0; dREN = 0;
    sample(); chk("midrst_ren", ramREN, 1'b0);
    advance();

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      RST      = ($urandom_range(0, 39) == 0);
      halt     = ($urandom_range(0, 3) == 0);
      iREN     = ($urandom_range(0, 2) != 0);
      dREN     = $urandom_range(0, 1);
      dWEN     = ($urandom_range(0, 3) == 0);
      iaddr    = $urandom;
      daddr    = $urandom;
      dstore   = $urandom;
      ramload  = $urandom;
      ramstate = ramstate_t'($urandom_range(0, 3));
      step();
    end

    quiet(); RST = 0; step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
